// File: rtl/otf_digit_converter_pkg.sv
// Shared definitions for the on-the-fly signed-digit to two's-complement converter.
package otf_digit_converter_pkg;

  // Signed-digit encoding produced by the upstream selection stage
  localparam logic [1:0] DIGIT_ZERO    = 2'b00;
  localparam logic [1:0] DIGIT_NEG     = 2'b01;
  localparam logic [1:0] DIGIT_POS     = 2'b10;
  localparam logic [1:0] DIGIT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StConvert,
    StDone
  } state_e;

  // Counter must hold the larger of the skip count and the digit count
  function automatic int unsigned cnt_width(input int unsigned n_digits,
                                            input int unsigned delay);
    int unsigned max_v;
    max_v = (delay > n_digits) ? delay : n_digits;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/otf_append_cell.sv
// Next values of Q and QM after appending one signed digit (on-the-fly conversion step).
module otf_append_cell
  import otf_digit_converter_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_qm,
  input  logic [1:0]       i_digit,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qm,
  output logic             o_illegal
);

  // Select shifted Q/QM so that QM stays equal to Q - 1 after every step
  always_comb begin
    o_q       = {i_q[WIDTH-2:0], 1'b0};
    o_qm      = {i_qm[WIDTH-2:0], 1'b1};
    o_illegal = 1'b0;
    unique case (i_digit)
      DIGIT_POS: begin
        o_q  = {i_q[WIDTH-2:0], 1'b1};
        o_qm = {i_q[WIDTH-2:0], 1'b0};
      end
      DIGIT_NEG: begin
        o_q  = {i_qm[WIDTH-2:0], 1'b1};
        o_qm = {i_qm[WIDTH-2:0], 1'b0};
      end
      DIGIT_ZERO: begin
        o_q  = {i_q[WIDTH-2:0], 1'b0};
        o_qm = {i_qm[WIDTH-2:0], 1'b1};
      end
      DIGIT_ILLEGAL: begin
        // Treated as a zero digit, flagged to the caller
        o_illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/otf_digit_converter.sv
// Converts a stream of signed digits (MSD first) into a two's-complement integer on the fly.
module otf_digit_converter
  import otf_digit_converter_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 16,
  parameter int unsigned ONLINE_DELAY = 3
) (
  input  logic              clk,
  input  logic              asyn_reset_n,
  input  logic              start,
  input  logic              digit_valid,
  input  logic [1:0]        p_value,
  input  logic              result_ack,
  output logic              busy,
  output logic [N_DIGITS:0] result,
  output logic              result_valid,
  output logic              digit_err
);

  localparam int unsigned W    = N_DIGITS + 1;
  localparam int unsigned CntW = cnt_width(N_DIGITS, ONLINE_DELAY);
  localparam logic [CntW-1:0] LastDigit = CntW'(N_DIGITS - 1);
  localparam logic [CntW-1:0] LastSkip  = CntW'((ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0);

  state_e          r_state, w_state_d, w_state;
  logic [CntW-1:0] r_cnt, w_cnt_d, w_cnt;
  logic [W-1:0]    r_q, w_q_d, w_q;
  logic [W-1:0]    r_qm, w_qm_d, w_qm;
  logic [W-1:0]    r_result, w_result_d;
  logic            r_err, w_err_d, w_err;
  logic [W-1:0]    w_q_app, w_qm_app;
  logic            w_illegal;

  otf_append_cell #(
    .WIDTH(W)
  ) u_append_cell (
    .i_q      (w_q),
    .i_qm     (w_qm),
    .i_digit  (p_value),
    .o_q      (w_q_app),
    .o_qm     (w_qm_app),
    .o_illegal(w_illegal)
  );

  // State register
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Datapath registers: digit counter, Q/QM pair, captured result and sticky error
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      r_cnt    <= '0;
      r_q      <= '0;
      r_qm     <= '1;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_q      <= w_q_d;
      r_qm     <= w_qm_d;
      r_result <= w_result_d;
      r_err    <= w_err_d;
    end
  end

  // Next-state: start re-initialises first, then a same-cycle digit is processed against the
  // fresh operation so it counts as that operation's first digit
  always_comb begin
    w_state = start ? ((ONLINE_DELAY > 0) ? StSkip : StConvert) : r_state;
    w_cnt   = start ? '0   : r_cnt;
    w_q     = start ? '0   : r_q;
    w_qm    = start ? '1   : r_qm;
    w_err   = start ? 1'b0 : r_err;

    w_state_d  = w_state;
    w_cnt_d    = w_cnt;
    w_q_d      = w_q;
    w_qm_d     = w_qm;
    w_err_d    = w_err;
    w_result_d = r_result;

    case (w_state)
      StIdle: ;
      StSkip: begin
        if (digit_valid) begin
          if (w_cnt == LastSkip) begin
            w_state_d = StConvert;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = w_cnt + 1'b1;
          end
        end
      end
      StConvert: begin
        if (digit_valid) begin
          w_q_d   = w_q_app;
          w_qm_d  = w_qm_app;
          w_err_d = w_err | w_illegal;
          if (w_cnt == LastDigit) begin
            w_state_d  = StDone;
            w_cnt_d    = '0;
            w_result_d = w_q_app;
          end else begin
            w_cnt_d = w_cnt + 1'b1;
          end
        end
      end
      StDone: begin
        if (result_ack) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    busy         = (r_state == StSkip) || (r_state == StConvert);
    result_valid = (r_state == StDone);
    result       = r_result;
    digit_err    = r_err;
  end

endmodule

// File: tb/tb_otf_digit_converter.sv
// Self-checking bench: vector table, randomized operations against an arithmetic model,
// and directed abort/reset/done-state sequences.
module tb_otf_digit_converter;

  localparam int unsigned N  = 8;
  localparam int unsigned OD = 3;

  typedef logic [N-1:0][1:0] digits_t;  // first digit at index N-1

  typedef struct {
    string      name;
    digits_t    ds;
    logic [N:0] exp;
    logic       err;
    bit         gaps;
  } vec_t;

  logic       clk = 1'b0;
  logic       asyn_reset_n;
  logic       start;
  logic       digit_valid;
  logic [1:0] p_value;
  logic       result_ack;
  logic       busy;
  logic [N:0] result;
  logic       result_valid;
  logic       digit_err;

  int errors = 0;
  int checks = 0;

  otf_digit_converter #(
    .N_DIGITS    (N),
    .ONLINE_DELAY(OD)
  ) dut (
    .clk         (clk),
    .asyn_reset_n(asyn_reset_n),
    .start       (start),
    .digit_valid (digit_valid),
    .p_value     (p_value),
    .result_ack  (result_ack),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: the result is the plain integer value of the digit string, wrapped to N+1 bits
  function automatic logic [N:0] model(input digits_t ds);
    int v;
    v = 0;
    for (int i = 0; i < N; i++) begin
      case (ds[N-1-i])
        2'b10:   v = v * 2 + 1;
        2'b01:   v = v * 2 - 1;
        default: v = v * 2;
      endcase
    end
    return v[N:0];
  endfunction

  function automatic logic model_err(input digits_t ds);
    logic e;
    e = 1'b0;
    for (int i = 0; i < N; i++) if (ds[i] == 2'b11) e = 1'b1;
    return e;
  endfunction

  function automatic logic [1:0] rand_legal();
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  // One digit strobe; p_value is left at the illegal code while idle to expose ignored strobes
  task automatic send(input logic [1:0] d, input bit gaps);
    idle(gaps);
    digit_valid = 1'b1;
    p_value     = d;
    tick();
    digit_valid = 1'b0;
    p_value     = 2'b11;
  endtask

  task automatic begin_op(input bit coincide, input bit gaps);
    start = 1'b1;
    if (coincide) begin
      digit_valid = 1'b1;
      p_value     = rand_legal();
    end
    tick();
    start       = 1'b0;
    digit_valid = 1'b0;
    p_value     = 2'b11;
    chk("busy_after_start", busy, 1);
    repeat (coincide ? OD - 1 : OD) send(rand_legal(), gaps);
  endtask

  task automatic run_op(input digits_t ds, input bit gaps, input bit coincide);
    begin_op(coincide, gaps);
    for (int i = 0; i < N; i++) begin
      send(ds[N-1-i], gaps);
      if (i == N - 2) chk("no_early_valid", result_valid, 0);
    end
    chk("valid_after_last", result_valid, 1);
    chk("busy_in_done", busy, 0);
  endtask

  task automatic ack_op(input logic [N:0] held);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("valid_after_ack", result_valid, 0);
    chk("result_held", result, held);
  endtask

  vec_t vecs[7];

  initial begin
    digits_t    ds;
    logic [N:0] exp;
    bit         seen_valid;

    vecs[0] = '{"all_pos",   {N{2'b10}},                     9'h0FF, 1'b0, 1'b0};
    vecs[1] = '{"pos_neg",   {2'b10, 2'b01, {6{2'b00}}},     9'h040, 1'b0, 1'b0};
    vecs[2] = '{"all_neg",   {N{2'b01}},                     9'h101, 1'b0, 1'b1};
    vecs[3] = '{"alt_np",    {4{2'b01, 2'b10}},              9'h1AB, 1'b0, 1'b0};
    vecs[4] = '{"illegal4",  {2'b10, 2'b00, 2'b00, 2'b11,
                              2'b00, 2'b00, 2'b00, 2'b01},   9'h07F, 1'b1, 1'b1};
    vecs[5] = '{"all_zero",  {N{2'b00}},                     9'h000, 1'b0, 1'b0};
    vecs[6] = '{"neg_first", {2'b01, {6{2'b00}}, 2'b10},     9'h181, 1'b0, 1'b1};

    asyn_reset_n = 1'b0;
    start        = 1'b0;
    digit_valid  = 1'b0;
    p_value      = 2'b11;
    result_ack   = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_err", digit_err, 0);
    repeat (2) tick();
    asyn_reset_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].ds, vecs[v].gaps, 1'b0);
      chk({vecs[v].name, "_result"}, result, vecs[v].exp);
      chk({vecs[v].name, "_err"}, digit_err, vecs[v].err);
      ack_op(vecs[v].exp);
    end

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) ds[i] = ($urandom_range(0, 7) == 0) ? 2'b11 : rand_legal();
      exp = model(ds);
      run_op(ds, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      chk("rand_result", result, exp);
      chk("rand_err", digit_err, model_err(ds));
      ack_op(exp);
    end

    // Abort after five converted digits (one illegal); only the second operation may complete
    begin_op(1'b0, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    repeat (3) send(2'b10, 1'b0);
    chk("abort_err_set", digit_err, 1);
    chk("abort_no_valid", result_valid, 0);
    chk("abort_result_held", result, exp);
    ds = {2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10};
    run_op(ds, 1'b0, 1'b0);
    chk("abort_second_result", result, model(ds));
    chk("abort_err_cleared", digit_err, 0);

    // Digit strobes in DONE are ignored
    repeat (3) send(2'b10, 1'b0);
    chk("done_ignores_valid", result_valid, 1);
    chk("done_ignores_result", result, model(ds));

    // start together with result_ack in DONE restarts rather than returning to idle
    ds = {2'b11, {7{2'b10}}};
    run_op(ds, 1'b0, 1'b0);
    chk("err_before_restart", digit_err, 1);
    start      = 1'b1;
    result_ack = 1'b1;
    tick();
    start      = 1'b0;
    result_ack = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_valid", result_valid, 0);
    chk("restart_err", digit_err, 0);
    chk("restart_result_held", result, model(ds));
    repeat (OD) send(2'b00, 1'b0);
    for (int i = 0; i < N; i++) send(2'b01, 1'b0);
    chk("restart_result", result, 9'h101);
    chk("restart_done", result_valid, 1);
    ack_op(9'h101);

    // Reset in the middle of conversion clears everything without any clock edge
    begin_op(1'b0, 1'b0);
    repeat (4) send(2'b10, 1'b0);
    #2;
    asyn_reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_err", digit_err, 0);
    tick();
    asyn_reset_n = 1'b1;
    seen_valid   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send(2'b10, 1'b0);
      if (result_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    chk("midrst_stays_idle", seen_valid, 0);

    ds = {2'b10, {6{2'b00}}, 2'b10};
    run_op(ds, 1'b1, 1'b1);
    chk("post_rst_result", result, 9'h081);
    ack_op(9'h081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otf_digit_converter.md
OTF_DIGIT_CONVERTER -- requirements
Module: otf_digit_converter

Interface
REQ-001 Parameter N_DIGITS, default 16: number of result digits converted per operation.
REQ-002 Parameter ONLINE_DELAY, default 3: number of leading digit strobes discarded after start.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port asyn_reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port start  input  1: single-cycle pulse that begins a new operation.
REQ-006 Port digit_valid  input  1: p_value carries a digit this cycle.
REQ-007 Port p_value  input  2: signed digit from the upstream selection stage, encoded 2'b10=+1, 2'b01=-1, 2'b00=0, 2'b11=illegal.
REQ-008 Port result_ack  input  1: consumer has taken result.
REQ-009 Port busy  output  1: high in SKIP and CONVERT.
REQ-010 Port result  output  N_DIGITS+1: two's-complement integer sum of d_i*2^(N_DIGITS-i), i=1..N_DIGITS.
REQ-011 Port result_valid  output  1: result stable and valid; held until acknowledged.
REQ-012 Port digit_err  output  1: sticky flag, an illegal digit was accepted in the current operation.

Function
REQ-013 FSM states SHALL be IDLE, SKIP, CONVERT, DONE.
REQ-014 IDLE: start -> SKIP if ONLINE_DELAY>0, else CONVERT; digit counter cleared, Q cleared to all zeros, QM set to all ones, digit_err cleared.
REQ-015 SKIP: each digit_valid increments the counter, digit discarded; when counter reaches ONLINE_DELAY-1 with digit_valid -> CONVERT, counter cleared.
REQ-016 CONVERT: each digit_valid applies on-the-fly conversion, all shifts within N_DIGITS+1 bits: d=+1 -> Q={Q,1}, QM={Q,0}; d=0 -> Q={Q,0}, QM={QM,1}; d=-1 -> Q={QM,1}, QM={QM,0}.
REQ-017 An illegal digit 2'b11 SHALL be converted as 0 and SHALL set digit_err.
REQ-018 digit_valid low SHALL leave counter, Q, QM unchanged in every state.
REQ-019 On the N_DIGITS-th accepted digit the FSM -> DONE; result and result_valid update in that same clock edge (latency 1 cycle from last digit).
REQ-020 DONE: result=Q, result_valid=1; result_ack -> IDLE, result_valid low on the next edge; digit_valid ignored.
REQ-021 start in any state (including DONE, or simultaneous with result_ack) SHALL abort/discard and re-initialise per REQ-014; start has priority over all other events.
REQ-022 start coincident with digit_valid: digit SHALL be treated as the first digit of the new operation (counted per REQ-015/016).
REQ-023 result SHALL hold its last value outside DONE; result_valid low outside DONE.
REQ-024 QM invariant: QM = Q - 1 (mod 2^(N_DIGITS+1)) after every accepted CONVERT digit.

Reset
REQ-025 asyn_reset_n low SHALL immediately force IDLE, counter=0, Q=0, QM=all ones, result=0, result_valid=0, busy=0, digit_err=0.
REQ-026 Reset asserted mid-operation SHALL discard the partial result; no result_valid pulse follows deassertion.

Structure
REQ-027 Shared package SHALL hold the digit encoding constants (DIGIT_POS, DIGIT_NEG, DIGIT_ZERO) and the FSM state typedef.
REQ-028 Counter width SHALL be $clog2 of max(ONLINE_DELAY, N_DIGITS)+1.
REQ-029 One sub-module otf_append_cell (combinational Q/QM next-value for one digit) is natural; FSM and registers stay in the top module.

Verification (N_DIGITS=8, ONLINE_DELAY=3)
REQ-030 start, 3 skip digits, then eight +1 -> result=9'h0FF, result_valid one cycle after last digit.
REQ-031 start, 3 skip, then +1,-1,0,0,0,0,0,0 -> result=9'h040 (64).
REQ-032 start, 3 skip, then eight -1 -> result=9'h101 (-255); alternating -1,+1 x4 -> 9'h1AB (-85).
REQ-033 Digits with gaps in digit_valid, one digit 2'b11 at position 4 -> converted as 0, digit_err=1, result matches model.
REQ-034 start reissued after 5 converted digits, then full 8-digit stream -> only the second operation's result appears.
REQ-035 asyn_reset_n pulsed low during CONVERT -> all outputs zero asynchronously, FSM IDLE, no result_valid afterwards.
